// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory req/ack and downstream valid/ready.
// master = fetch stage, slave = memory plus the control unit.
interface instruction_fetch_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32
);
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_addr;
  logic [2:0]         command_group;
  logic [2:0]         command;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    output instr_valid, instr, instr_addr,
    output command_group, command,
    input  instr_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    input  instr_valid, instr, instr_addr,
    input  command_group, command,
    output instr_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: IP, memory req/ack, instruction register, redirects.
// Optional FETCH_PERF_EN adds a saturating handshake counter.
module instruction_fetch #(
  parameter int              ADDR_W     = 8,
  parameter int              INSTR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  instruction_fetch_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       fetch_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ip;
  logic [ADDR_W-1:0] next_ip;
  logic              kill;

  assign next_ip = redirect ? redirect_addr : ip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ip              <= RESET_ADDR;
      kill            <= 1'b0;
      bus.mem_req     <= 1'b0;
      bus.mem_addr    <= RESET_ADDR;
      bus.instr_valid <= 1'b0;
      bus.instr       <= '0;
      bus.instr_addr  <= '0;
    end else begin
      if (redirect) ip <= redirect_addr;
      unique case (state)
        IDLE: begin
          if (enable) begin
            state        <= FETCH;
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= next_ip;
          end
        end
        FETCH: begin
          if (bus.mem_ack) begin
            kill <= 1'b0;
            if (redirect || kill) begin
              // stale response: refetch from the redirected IP
              bus.mem_req  <= enable;
              bus.mem_addr <= next_ip;
              state        <= enable ? FETCH : IDLE;
            end else begin
              bus.instr       <= bus.mem_rdata;
              bus.instr_addr  <= bus.mem_addr;
              bus.instr_valid <= 1'b1;
              bus.mem_req     <= 1'b0;
              ip              <= bus.mem_addr + 1'b1;
              state           <= HOLD;
            end
          end else if (redirect) begin
            kill <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect || bus.instr_ready) begin
            bus.instr_valid <= 1'b0;
            bus.mem_req     <= enable;
            bus.mem_addr    <= next_ip;
            state           <= enable ? FETCH : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.command_group = bus.instr_valid ?
                             bus.instr[INSTR_W-1 -: 3] : 3'b000;
  assign bus.command       = bus.instr_valid ?
                             bus.instr[INSTR_W-4 -: 3] : 3'b000;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (bus.instr_valid && bus.instr_ready &&
                 fetch_count != 16'hFFFF) begin
      fetch_count <= fetch_count + 16'd1;
    end
  end
`endif

endmodule
